// File: rtl/param_scheduler.sv
// Parameter-slot scheduler: responds to the top-level controller state, scans a pending
// bitmap round-robin during GET_PARAM and retires converged slots in WRITE_BACK.
module param_scheduler #(
   parameter int N_PARAM  = 16,
   parameter int IDX_W    = 4,
   parameter int ITER_W   = 16,
   parameter int MAX_ITER = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         state,
   input  logic [N_PARAM-1:0] valid_mask,
   input  logic               ex_converged,
   output logic               is_find,
   output logic               is_finish,
   output logic [IDX_W-1:0]   param_idx,
   output logic [ITER_W-1:0]  iter_cnt,
   output logic [N_PARAM-1:0] pending
);

   localparam logic [2:0] ST_IDLE       = 3'b000;
   localparam logic [2:0] ST_GET_PARAM  = 3'b001;
   localparam logic [2:0] ST_GET_DATA   = 3'b010;
   localparam logic [2:0] ST_EX         = 3'b011;
   localparam logic [2:0] ST_WRITE_BACK = 3'b100;

   logic [N_PARAM-1:0] r_pending, w_pending;
   logic [IDX_W-1:0]   r_ptr,     w_ptr;
   logic [IDX_W-1:0]   r_idx,     w_idx;
   logic [ITER_W-1:0]  r_iter,    w_iter;
   logic               r_find,    w_find;
   logic               r_finish,  w_finish;

   logic [IDX_W-1:0]   w_ptr_inc;
   logic               w_wrap;
   logic [ITER_W-1:0]  w_iter_inc;
   logic               w_cap_hit;

   assign w_ptr_inc  = r_ptr + IDX_W'(1);
   assign w_wrap     = (r_ptr == IDX_W'(N_PARAM - 1));
   assign w_iter_inc = (r_iter == '1) ? r_iter : r_iter + ITER_W'(1);
   // Widened compare so a saturated counter can never alias onto MAX_ITER.
   assign w_cap_hit  = (({1'b0, r_iter} + (ITER_W+1)'(1)) == (ITER_W+1)'(MAX_ITER));

   always_comb begin
      w_pending = r_pending;
      w_ptr     = r_ptr;
      w_idx     = r_idx;
      w_iter    = r_iter;
      w_find    = r_find;
      w_finish  = r_finish;
      case (state)
         ST_IDLE: begin
            w_pending = valid_mask;
            w_ptr     = '0;
            w_iter    = '0;
            w_find    = 1'b0;
            w_finish  = 1'b0;
         end
         ST_GET_PARAM: begin
            // A found slot is held while the controller is still one cycle behind.
            if (!r_find) begin
               if (r_pending == '0) begin
                  w_finish = 1'b1;
               end else begin
                  if (r_pending[r_ptr]) begin
                     w_find = 1'b1;
                     w_idx  = r_ptr;
                  end
                  w_ptr = w_ptr_inc;
                  if (w_wrap) begin
                     w_iter = w_iter_inc;
                     if (w_cap_hit) w_finish = 1'b1;
                  end
               end
            end
         end
         ST_GET_DATA, ST_EX: begin
            w_find = 1'b0;
         end
         ST_WRITE_BACK: begin
            if (ex_converged) w_pending[r_idx] = 1'b0;
            w_find = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_ptr     <= '0;
         r_idx     <= '0;
         r_iter    <= '0;
         r_find    <= 1'b0;
         r_finish  <= 1'b0;
      end else begin
         r_pending <= w_pending;
         r_ptr     <= w_ptr;
         r_idx     <= w_idx;
         r_iter    <= w_iter;
         r_find    <= w_find;
         r_finish  <= w_finish;
      end
   end

   assign is_find   = r_find;
   assign is_finish = r_finish;
   assign param_idx = r_idx;
   assign iter_cnt  = r_iter;
   assign pending   = r_pending;

endmodule

// File: tb/tb_param_scheduler.sv
// Bench for param_scheduler: two instances (default cap, and a tiny cap/counter width)
// checked every cycle against a slot-level model plus directed literal expectations.
module tb_param_scheduler;

   localparam logic [2:0] IDLE = 3'd0, GETP = 3'd1, GETD = 3'd2, EXS = 3'd3, WB = 3'd4, DONE = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  state = IDLE;
   logic [15:0] valid_mask = '0;
   logic        ex_converged = 1'b0;

   logic        a_find, a_finish, b_find, b_finish;
   logic [3:0]  a_idx, b_idx;
   logic [15:0] a_iter;
   logic [2:0]  b_iter;
   logic [15:0] a_pend, b_pend;

   param_scheduler #(.N_PARAM(16), .IDX_W(4), .ITER_W(16), .MAX_ITER(1000)) u_a (
      .clk(clk), .rst_n(rst_n), .state(state), .valid_mask(valid_mask),
      .ex_converged(ex_converged), .is_find(a_find), .is_finish(a_finish),
      .param_idx(a_idx), .iter_cnt(a_iter), .pending(a_pend));

   param_scheduler #(.N_PARAM(16), .IDX_W(4), .ITER_W(3), .MAX_ITER(2)) u_b (
      .clk(clk), .rst_n(rst_n), .state(state), .valid_mask(valid_mask),
      .ex_converged(ex_converged), .is_find(b_find), .is_finish(b_finish),
      .param_idx(b_idx), .iter_cnt(b_iter), .pending(b_pend));

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slot-level model: index 0 = instance A, 1 = instance B
   int        m_ptr[2], m_iter[2], m_idx[2];
   bit        m_find[2], m_fin[2];
   bit [15:0] m_pend[2];
   int        m_cap[2] = '{1000, 2};
   int        m_sat[2] = '{65535, 7};

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_pend[i] = '0; m_ptr[i] = 0; m_iter[i] = 0; m_idx[i] = 0;
            m_find[i] = 0;  m_fin[i] = 0;
         end else begin
            case (state)
               IDLE: begin
                  m_pend[i] = valid_mask; m_ptr[i] = 0; m_iter[i] = 0;
                  m_find[i] = 0; m_fin[i] = 0;
               end
               GETP: begin
                  if (!m_find[i]) begin
                     if (m_pend[i] == 0) m_fin[i] = 1;
                     else begin
                        if (m_pend[i][m_ptr[i]]) begin
                           m_find[i] = 1;
                           m_idx[i]  = m_ptr[i];
                        end
                        m_ptr[i] = (m_ptr[i] + 1) % 16;
                        if (m_ptr[i] == 0) begin
                           if (m_iter[i] + 1 == m_cap[i]) m_fin[i] = 1;
                           if (m_iter[i] < m_sat[i]) m_iter[i] = m_iter[i] + 1;
                        end
                     end
                  end
               end
               GETD, EXS: m_find[i] = 0;
               WB: begin
                  if (ex_converged) m_pend[i][m_idx[i]] = 1'b0;
                  m_find[i] = 0;
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("A.is_find",   32'(a_find),   32'(m_find[0]));
         check("A.is_finish", 32'(a_finish), 32'(m_fin[0]));
         check("A.param_idx", 32'(a_idx),    32'(m_idx[0]));
         check("A.iter_cnt",  32'(a_iter),   32'(m_iter[0]));
         check("A.pending",   32'(a_pend),   32'(m_pend[0]));
         check("B.is_find",   32'(b_find),   32'(m_find[1]));
         check("B.is_finish", 32'(b_finish), 32'(m_fin[1]));
         check("B.param_idx", 32'(b_idx),    32'(m_idx[1]));
         check("B.iter_cnt",  32'(b_iter),   32'(m_iter[1]));
         check("B.pending",   32'(b_pend),   32'(m_pend[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [2:0] st);
      state = st;
      tick();
   endtask

   task automatic wait_find(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (a_find !== 1'b1 && n < 40);
   endtask

   task automatic pass_slot(input logic conv);
      step(GETD);
      step(EXS);
      ex_converged = conv;
      step(WB);
      ex_converged = 1'b0;
   endtask

   int n;

   initial begin
      tick();
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      check("rst.is_find",   32'(a_find),   0);
      check("rst.is_finish", 32'(a_finish), 0);
      check("rst.pending",   32'(a_pend),   0);

      // single slot
      valid_mask = 16'h0001;
      step(IDLE);
      check("s1.pending_load", 32'(a_pend), 32'h0001);
      step(GETP);
      check("s1.is_find", 32'(a_find), 1);
      check("s1.idx",     32'(a_idx),  0);
      tick();
      check("s1.lag_hold", 32'(a_find), 1);
      pass_slot(1'b1);
      check("s1.retired", 32'(a_pend), 0);
      step(GETP);
      check("s1.finish",      32'(a_finish), 1);
      check("s1.no_find",     32'(a_find),   0);
      step(DONE);
      tick();
      check("s1.finish_sticky", 32'(a_finish), 1);

      // worst-case scan latency
      valid_mask = 16'h8000;
      step(IDLE);
      check("s2.finish_clr", 32'(a_finish), 0);
      state = GETP;
      repeat (15) tick();
      check("s2.not_yet", 32'(a_find), 0);
      tick();
      check("s2.is_find", 32'(a_find), 1);
      check("s2.idx",     32'(a_idx),  15);
      check("s2.iter",    32'(a_iter), 1);
      pass_slot(1'b1);
      step(GETP);
      check("s2.finish", 32'(a_finish), 1);

      // round robin with a non-converged slot
      valid_mask = 16'h0005;
      step(IDLE);
      step(GETP);
      check("s3.first_idx", 32'(a_idx), 0);
      tick();
      pass_slot(1'b0);
      state = GETP;
      wait_find(n);
      check("s3.lat2", 32'(n), 2);
      check("s3.idx2", 32'(a_idx), 2);
      pass_slot(1'b1);
      check("s3.pending", 32'(a_pend), 32'h0001);
      state = GETP;
      wait_find(n);
      check("s3.lat_wrap", 32'(n), 14);
      check("s3.idx0",     32'(a_idx), 0);
      check("s3.iter",     32'(a_iter), 1);

      // iteration cap (instance B, MAX_ITER=2)
      valid_mask = 16'h0001;
      step(IDLE);
      step(GETP);
      pass_slot(1'b0);
      state = GETP;
      wait_find(n);
      check("s4.lat", 32'(n), 16);
      check("s4.b_iter1", 32'(b_iter), 1);
      check("s4.b_nofin", 32'(b_finish), 0);
      pass_slot(1'b0);
      state = GETP;
      n = 0;
      do begin
         tick();
         n++;
      end while (b_finish !== 1'b1 && n < 40);
      check("s4.cap_cycle", 32'(n), 15);
      check("s4.b_iter2",   32'(b_iter), 2);
      check("s4.a_nofin",   32'(a_finish), 0);
      tick();
      check("s4.b_find_after", 32'(b_find), 1);
      check("s4.b_fin_sticky", 32'(b_finish), 1);

      // find and cap-finish in the same cycle, then counter saturation
      valid_mask = 16'h8000;
      step(IDLE);
      state = GETP;
      wait_find(n);
      step(GETD);
      state = GETP;
      wait_find(n);
      check("s5.both_find", 32'(b_find),   1);
      check("s5.both_fin",  32'(b_finish), 1);
      check("s5.idx",       32'(b_idx),    15);
      for (int k = 0; k < 7; k++) begin
         step(GETD);
         state = GETP;
         wait_find(n);
      end
      check("s5.b_sat",  32'(b_iter), 7);
      check("s5.a_iter", 32'(a_iter), 9);

      // empty mask
      valid_mask = 16'h0000;
      step(IDLE);
      check("s6.clr", 32'(b_finish), 0);
      step(GETP);
      check("s6.finish", 32'(a_finish), 1);
      repeat (3) tick();
      check("s6.no_find", 32'(a_find), 0);

      // asynchronous reset mid-cycle
      valid_mask = 16'h00F0;
      step(IDLE);
      state = GETP;
      wait_find(n);
      check("s7.lat", 32'(n), 5);
      check("s7.idx", 32'(a_idx), 4);
      #2;
      rst_n = 1'b0;
      #1;
      check("s7.find0", 32'(a_find),   0);
      check("s7.idx0",  32'(a_idx),    0);
      check("s7.pend0", 32'(a_pend),   0);
      check("s7.fin0",  32'(b_finish), 0);
      check("s7.iter0", 32'(b_iter),   0);
      state = IDLE;
      tick();
      rst_n = 1'b1;
      tick();
      check("s7.reload", 32'(a_pend), 32'h00F0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
